// File: rtl/memory_dreq_ctrl.sv
// Memory-stage data-bus request controller: IDLE/REQ/WAIT/DONE handshake.
// Define MISALIGN_CHECK_EN to block misaligned halfword/word accesses.
module memory_dreq_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [1:0]  msize,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        advance,
  input  logic        flush,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic [31:0] raw_data,
  output logic        done,
  output logic        stall,
  output logic        addr_err
);

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        dreq_valid_q, dreq_valid_d;
  logic [31:0] dreq_addr_q, dreq_addr_d;
  logic [1:0]  dreq_size_q, dreq_size_d;
  logic [3:0]  dreq_strobe_q, dreq_strobe_d;
  logic [31:0] dreq_data_q, dreq_data_d;
  logic [31:0] raw_data_q, raw_data_d;
  logic        done_q, done_d;

  logic        is_mem, misal, launch, kill;
  logic [3:0]  strobe_n;
  logic [31:0] data_n;
  logic [4:0]  sh;

  assign is_mem = mem_valid & (mem_load | mem_store);

  always_comb begin
    sh = {mem_addr[1:0], 3'b000};
    unique case (msize)
      MSIZE1: begin
        strobe_n = 4'b0001 << mem_addr[1:0];
        data_n   = mem_wdata << sh;
      end
      MSIZE2: begin
        strobe_n = 4'b0011 << mem_addr[1:0];
        data_n   = mem_wdata << sh;
      end
      default: begin
        strobe_n = 4'b1111;
        data_n   = mem_wdata;
      end
    endcase
    if (!mem_store) strobe_n = 4'b0000;
  end

`ifdef MISALIGN_CHECK_EN
  assign misal = (msize == MSIZE2 && mem_addr[0]) ||
                 (msize == MSIZE4 && mem_addr[1:0] != 2'b00);
  assign addr_err = resetn && state_q == IDLE && is_mem && misal;
`else
  assign misal    = 1'b0;
  assign addr_err = 1'b0;
`endif

  assign launch = resetn && state_q == IDLE && is_mem && !flush && !misal;
  // A flush seen while the bus is busy only marks the access; it still drains.
  assign kill   = cancel_q | flush;

  always_comb begin
    state_d       = state_q;
    cancel_d      = cancel_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_size_d   = dreq_size_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    raw_data_d    = raw_data_q;
    done_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d       = REQ;
          cancel_d      = 1'b0;
          dreq_valid_d  = 1'b1;
          dreq_addr_d   = mem_addr;
          dreq_size_d   = msize;
          dreq_strobe_d = strobe_n;
          dreq_data_d   = data_n;
        end
      end
      REQ: begin
        cancel_d = kill;
        if (dresp_addr_ok) begin
          dreq_valid_d = 1'b0;
          if (dresp_data_ok) begin
            cancel_d = 1'b0;
            if (kill) begin
              state_d = IDLE;
            end else begin
              state_d    = DONE;
              raw_data_d = dresp_data;
              done_d     = 1'b1;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cancel_d = kill;
        if (dresp_data_ok) begin
          cancel_d = 1'b0;
          if (kill) begin
            state_d = IDLE;
          end else begin
            state_d    = DONE;
            raw_data_d = dresp_data;
            done_d     = 1'b1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (flush || advance) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cancel_q      <= 1'b0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      raw_data_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cancel_q      <= cancel_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_size_q   <= dreq_size_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      raw_data_q    <= raw_data_d;
      done_q        <= done_d;
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;
  assign raw_data    = raw_data_q;
  assign done        = done_q;
  assign stall       = state_q == REQ || state_q == WAIT || launch;

endmodule

// File: tb/tb_memory_dreq_ctrl.sv
// Scoreboard bench for memory_dreq_ctrl: request and load-result queues
// are checked by a negedge monitor while directed accesses are driven.
module tb_memory_dreq_ctrl;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_load, mem_store;
  logic [1:0]  msize;
  logic [31:0] mem_addr, mem_wdata;
  logic        advance, flush;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic [31:0] raw_data;
  logic        done, stall, addr_err;

  always #5 clk = ~clk;

  memory_dreq_ctrl dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_load(mem_load), .mem_store(mem_store),
    .msize(msize), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .advance(advance), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_data(dresp_data),
    .raw_data(raw_data), .done(done), .stall(stall),
    .addr_err(addr_err)
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
    logic [3:0]  st;
    logic [31:0] d;
  } req_t;

  req_t        rq[$];
  logic [31:0] dq[$];
  logic [31:0] last_raw;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (dreq_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_req", dreq_valid, 0);
        end else begin
          chk("dreq_addr", dreq_addr, rq[0].a);
          chk("dreq_size", dreq_size, rq[0].s);
          chk("dreq_strobe", dreq_strobe, rq[0].st);
          chk("dreq_data", dreq_data, rq[0].d);
          if (dresp_addr_ok) void'(rq.pop_front());
        end
      end
      if (done && advance) begin
        if (dq.size() == 0) chk("unexpected_done", done, 0);
        else chk("raw_data", raw_data, dq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_load = 0; mem_store = 0;
    msize = MSIZE4; mem_addr = 0; mem_wdata = 0;
    advance = 0; flush = 0;
    dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
  endtask

  // ao: addr_ok cycle, dk: data_ok cycle, fl: flush cycle (-1 none)
  task automatic do_access(input logic ld, input logic st,
                           input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] exp_st,
                           input logic [31:0] exp_d, input int ao,
                           input int dk, input logic [31:0] rd,
                           input int fl, input bit kill_done);
    bit flushed;
    flushed = (fl >= 0);
    rq.push_back('{a, sz, exp_st, exp_d});
    if (!flushed && !kill_done) dq.push_back(rd);
    for (int c = 0; c <= dk + 1; c++) begin
      mem_valid = (c <= dk) && !(flushed && c > fl);
      mem_load = ld; mem_store = st; msize = sz;
      mem_addr = a; mem_wdata = wd;
      dresp_addr_ok = (c == ao);
      dresp_data_ok = (c == dk);
      dresp_data = (c == dk) ? rd : 32'h0BAD_0BAD;
      flush = (c == fl) || (kill_done && c == dk + 1);
      advance = (c == dk + 1) && !flushed && !kill_done;
      @(negedge clk);
      if (c == 0) chk("addr_err_ok", addr_err, 0);
      if (c <= dk) begin
        chk("stall_busy", stall, 1);
        chk("dreq_valid", dreq_valid, (c >= 1 && c <= ao));
        chk("done_early", done, 0);
      end else begin
        chk("done_end", done, !flushed);
        chk("stall_end", stall, 0);
      end
      step();
    end
    idle_inputs();
    if (!flushed) last_raw = rd;
    @(negedge clk);
    chk("done_after", done, 0);
    chk("raw_after", raw_data, last_raw);
    chk("stall_after", stall, 0);
    step();
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    last_raw = 0;
    #12;
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_raw", raw_data, 0);
    chk("rst_done", done, 0);
    chk("rst_strobe", dreq_strobe, 0);
    step();
    resetn = 1;
    step();

    // load word, addr_ok cycle 1, data_ok cycle 3
    do_access(1, 0, MSIZE4, 32'h8000_0010, 32'h0, 4'b0000, 32'h0,
              1, 3, 32'hDEAD_BEEF, -1, 0);
    // store byte held until late addr_ok
    do_access(0, 1, MSIZE1, 32'h8000_0003, 32'h0000_00A5, 4'b1000,
              32'hA500_0000, 3, 4, 32'h1111_1111, -1, 0);
    // addr_ok and data_ok together
    do_access(1, 0, MSIZE4, 32'h8000_0020, 32'h0, 4'b0000, 32'h0,
              1, 1, 32'h1234_5678, -1, 0);
    // store halfword upper lane
    do_access(0, 1, MSIZE2, 32'h8000_0006, 32'h0000_BEEF, 4'b1100,
              32'hBEEF_0000, 2, 3, 32'h0, -1, 0);
    // load byte lane 1: strobe 0, data still shifted
    do_access(1, 0, MSIZE1, 32'h8000_0001, 32'h0000_00FF, 4'b0000,
              32'h0000_FF00, 1, 2, 32'hCAFE_BABE, -1, 0);
    // flush during WAIT
    do_access(1, 0, MSIZE4, 32'h8000_0030, 32'h0, 4'b0000, 32'h0,
              1, 4, 32'hFFFF_FFFF, 2, 0);
    // flush during REQ keeps request up until addr_ok
    do_access(1, 0, MSIZE4, 32'h8000_0034, 32'h0, 4'b0000, 32'h0,
              3, 3, 32'h7777_7777, 1, 0);
    // flush in DONE
    do_access(1, 0, MSIZE4, 32'h8000_0038, 32'h0, 4'b0000, 32'h0,
              1, 2, 32'h0BAD_CAFE, -1, 1);

    // non-memory instruction
    mem_valid = 1;
    @(negedge clk);
    chk("nonmem_stall", stall, 0);
    chk("nonmem_done", done, 0);
    step();
    mem_valid = 0;
    @(negedge clk);
    chk("nonmem_dreq", dreq_valid, 0);
    step();

    // stray data_ok while idle
    dresp_data_ok = 1; dresp_data = 32'h5A5A_5A5A;
    step();
    dresp_data_ok = 0;
    @(negedge clk);
    chk("stray_done", done, 0);
    chk("stray_raw", raw_data, last_raw);
    step();

    // misaligned word load
    mem_valid = 1; mem_load = 1; msize = MSIZE4; mem_addr = 32'h8000_0042;
`ifdef MISALIGN_CHECK_EN
    @(negedge clk);
    chk("misal_err", addr_err, 1);
    chk("misal_stall", stall, 0);
    step();
    @(negedge clk);
    chk("misal_noreq", dreq_valid, 0);
    step();
    @(negedge clk);
    chk("misal_noreq2", dreq_valid, 0);
    step();
    idle_inputs();
`else
    idle_inputs();
    do_access(1, 0, MSIZE4, 32'h8000_0042, 32'h0, 4'b0000, 32'h0,
              1, 2, 32'h3141_5926, -1, 0);
`endif

    // reset while in WAIT
    rq.push_back('{32'h8000_0040, MSIZE4, 4'b0000, 32'h0});
    mem_valid = 1; mem_load = 1; msize = MSIZE4; mem_addr = 32'h8000_0040;
    step();
    dresp_addr_ok = 1;
    step();
    dresp_addr_ok = 0;
    #2 resetn = 0;
    #1;
    chk("r_dreq_valid", dreq_valid, 0);
    chk("r_dreq_addr", dreq_addr, 0);
    chk("r_dreq_size", dreq_size, 0);
    chk("r_dreq_strobe", dreq_strobe, 0);
    chk("r_dreq_data", dreq_data, 0);
    chk("r_raw", raw_data, 0);
    chk("r_done", done, 0);
    chk("r_stall", stall, 0);
    chk("r_addr_err", addr_err, 0);
    mem_valid = 0; mem_load = 0;
    step();
    step();
    resetn = 1;
    last_raw = 0;
    dresp_data_ok = 1; dresp_data = 32'h5555_5555;
    @(negedge clk);
    chk("late_done", done, 0);
    chk("late_dreq", dreq_valid, 0);
    step();
    dresp_data_ok = 0;
    @(negedge clk);
    chk("late_done2", done, 0);
    chk("late_raw", raw_data, 0);
    step();

    chk("req_queue_empty", rq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_dreq_ctrl.md
MEMORY_DREQ_CTRL -- requirements
Module: memory_dreq_ctrl

Interface
REQ-001 SHALL have these ports (name direction width meaning); clock and reset come first.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  memory-stage instruction present.
- mem_load, mem_store  in  1 each  access type; at most one is asserted.
- msize  in  2  MSIZE1 / MSIZE2 / MSIZE4.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-aligned.
- advance  in  1  pipeline consumes the result this cycle.
- flush  in  1  kill the current instruction.
- dreq_valid  out  1  data-bus request valid.
- dreq_addr  out  32  request address.
- dreq_size  out  2  request size.
- dreq_strobe  out  4  byte write enables; 0 for loads.
- dreq_data  out  32  lane-aligned store data.
- dresp_addr_ok  in  1  request accepted.
- dresp_data_ok  in  1  response or write complete.
- dresp_data  in  32  raw load word.
- raw_data  out  32  captured word, fed to load-data extraction.
- done  out  1  access finished, result valid.
- stall  out  1  memory stage must hold.
- addr_err  out  1  misaligned address (only when MISALIGN_CHECK_EN is defined).
REQ-002 SHALL expose the ports exactly as REQ-001; no parameters.

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-004 IDLE -> REQ SHALL occur when mem_valid and (mem_load or mem_store) and not flush and no addr_err; a non-memory mem_valid SHALL give done=0, stall=0.
REQ-005 In REQ, dreq_valid SHALL be 1 and dreq_addr/size/strobe/data SHALL be held stable from registered copies until dresp_addr_ok.
REQ-006 REQ + addr_ok without data_ok SHALL go to WAIT. REQ + addr_ok + data_ok in the same cycle SHALL go to DONE.
REQ-007 WAIT + data_ok SHALL go to DONE; dresp_data SHALL be captured into raw_data on the data_ok cycle.
REQ-008 DONE SHALL assert done=1. DONE + advance SHALL go to IDLE, and the next access SHALL be accepted no earlier than the following cycle.
REQ-009 stall SHALL be 1 in REQ and WAIT, and in IDLE during the launch cycle of REQ-004. It SHALL be 0 in DONE and in other IDLE cycles.
REQ-010 dreq_strobe: MSIZE1 = 4'b0001 << addr[1:0]; MSIZE2 = 4'b0011 << addr[1:0]; MSIZE4 = 4'b1111. Loads SHALL use 4'b0000.
REQ-011 dreq_data SHALL be mem_wdata shifted left by 8*addr[1:0] (MSIZE1/MSIZE2); for MSIZE4 it SHALL be unchanged.
REQ-012 flush in REQ SHALL NOT drop dreq_valid before addr_ok. flush in REQ or WAIT SHALL set a cancel flag. The transaction SHALL drain to data_ok, then return to IDLE with done=0 and raw_data unchanged.
REQ-013 flush in DONE SHALL return to IDLE next cycle with done=0.
REQ-014 dresp_data_ok outside WAIT/REQ SHALL be ignored.

Reset
REQ-015 resetn=0 SHALL asynchronously force IDLE, dreq_valid=0, dreq_addr=0, dreq_size=0, dreq_strobe=0, dreq_data=0, raw_data=0, done=0, cancel=0, addr_err=0.
REQ-016 Reset mid-transaction SHALL abandon it; no done pulse SHALL follow reset release.

Configuration
REQ-017 Macro MISALIGN_CHECK_EN SHALL control misaligned-address checking.
REQ-018 With MISALIGN_CHECK_EN defined, a misaligned access SHALL raise combinational addr_err=1 in IDLE and SHALL issue no request:
- MSIZE2 with addr[0]=1.
- MSIZE4 with addr[1:0]!=0.
REQ-019 Without MISALIGN_CHECK_EN, the addr_err port SHALL be tied to 0 and every access SHALL be issued as given.

Verification
REQ-020 Load word, addr=0x8000_0010, addr_ok cycle 1, data_ok cycle 3, data=0xDEADBEEF -> strobe 0000, raw_data=0xDEADBEEF, done at cycle 4, stall cycles 0-3.
REQ-021 Store byte, addr=0x...03, wdata=0x000000A5 -> strobe 1000, dreq_data=0xA5000000, held until addr_ok.
REQ-022 addr_ok and data_ok in the same cycle (data=0x12345678) -> DONE next cycle, WAIT skipped.
REQ-023 flush during WAIT, then data_ok with data 0xFFFFFFFF -> done never asserted, raw_data unchanged, IDLE after data_ok.
REQ-024 resetn low during WAIT -> all outputs 0 immediately; late data_ok ignored.
REQ-025 With MISALIGN_CHECK_EN, MSIZE4 load at addr=0x...02 -> addr_err=1, dreq_valid stays 0. Without the macro -> request issued.
